// File: rtl/pwm_pkg.sv
// Shared types and helpers for the period-aligned PWM generator.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARM      = 2'd1,
      RUN      = 2'd2,
      STOPPING = 2'd3
   } state_t;

   // Limit a requested duty to the period length n; a duty of n means always high.
   function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned n);
      return (duty > n) ? n : duty;
   endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// Duty-update handshake between a duty source and the PWM generator.
interface pwm_compare_if #(
   parameter int N = 8
);
   localparam int X = $clog2(N);

   logic [X:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;

   modport master (output duty_in, output duty_valid, input duty_ready);
   modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/pwm_compare_duty_shadow.sv
// Double-buffered duty: a one-deep pending slot fed by the handshake and an
// active value that only moves on the apply strobe (period boundary).
module duty_shadow
   import pwm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 apply,
   input  logic [$clog2(N):0]   duty_in,
   input  logic                 duty_valid,
   output logic                 duty_ready,
   output logic [$clog2(N):0]   active
);

   localparam int DW = $clog2(N) + 1;

   logic [DW-1:0] pending;
   logic          full;
   logic          accept;

   // A full slot blocks new duties, so accept and apply never touch the
   // pending slot in the same cycle.
   assign duty_ready = !full;
   assign accept     = duty_valid && !full;

   // Pending/active pair; the clamp happens on the way into pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         full    <= 1'b0;
         active  <= '0;
      end else begin
         if (accept) begin
            pending <= DW'(clamp_duty(32'(duty_in), N));
            full    <= 1'b1;
         end else if (apply && full) begin
            active <= pending;
            full   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pwm_compare.sv
// PWM generator slaved to an upstream modulo-N counter. Duty changes and
// start/stop take effect only at period boundaries so no partial periods
// ever reach pwm_out.
module pwm_compare
   import pwm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [$clog2(N)-1:0] count_in,
   input  logic                 enable_in,
   input  logic                 start,
   input  logic                 stop,
   pwm_compare_if.slave         duty_bus,
   output logic                 pwm_out,
   output logic                 period_done,
   output logic                 busy
);

   localparam int X = $clog2(N);

   state_t     state, next_state;
   logic       boundary;
   logic       apply;
   logic       outputting;
   logic [X:0] active;

   // The upstream counter wraps to 0 on the edge that ends this cycle.
   assign boundary   = enable_in && (count_in == X'(N - 1));
   assign apply      = boundary && ((state == ARM) || (state == RUN));
   assign outputting = (state == RUN) || (state == STOPPING);
   assign busy       = (state != IDLE);

   duty_shadow #(.N(N)) u_shadow (
      .clk        (clk),
      .reset      (reset),
      .apply      (apply),
      .duty_in    (duty_bus.duty_in),
      .duty_valid (duty_bus.duty_valid),
      .duty_ready (duty_bus.duty_ready),
      .active     (active)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic; stop beats start whenever both are seen.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start && !stop) next_state = ARM;
         ARM:      if (stop)           next_state = IDLE;
                   else if (boundary)  next_state = RUN;
         RUN:      if (stop)           next_state = STOPPING;
         STOPPING: if (boundary)       next_state = IDLE;
         default:                      next_state = IDLE;
      endcase
   end

   // Registered compare and boundary pulse; a frozen count simply recomputes
   // the same compare result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         pwm_out     <= outputting && ({1'b0, count_in} < active);
         period_done <= outputting && boundary;
      end
   end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare at N=8; the bench plays the upstream counter.
module tb_pwm_compare;

   localparam int N = 8;
   localparam int X = $clog2(N);

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [X-1:0] cnt;
   logic         enable = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         pwm_out, period_done, busy;

   int n_chk = 0;
   int n_fail = 0;

   pwm_compare_if #(.N(N)) duty_bus ();

   pwm_compare #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .count_in    (cnt),
      .enable_in   (enable),
      .start       (start),
      .stop        (stop),
      .duty_bus    (duty_bus.slave),
      .pwm_out     (pwm_out),
      .period_done (period_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Upstream modulo-N counter.
   always @(posedge clk or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (enable) cnt <= (cnt == X'(N - 1)) ? '0 : cnt + 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_count(input int k);
      int t = 0;
      while (cnt != X'(k) && t < 64) begin
         step();
         t++;
      end
      if (t >= 64) begin
         chk("wait_count timeout", 32'(t), 32'(0));
         $display("FAIL wait_count: count never reached %0d", k);
         $fatal(1);
      end
   endtask

   // Load a duty at count 4 of the current period so it applies at its wrap.
   task automatic set_duty(input int v);
      wait_count(4);
      duty_bus.duty_in    = (X+1)'(v);
      duty_bus.duty_valid = 1'b1;
      step();
      duty_bus.duty_valid = 1'b0;
   endtask

   // Record one period: bit c of bits is pwm_out for count c (one-cycle lag).
   // Optionally offers a duty at count ld_at plus a second offer right after,
   // and pulses stop at count stop_at.
   task automatic capture(input int ld_at, input int ld_val, input int stop_at,
                          output logic [7:0] bits, output int pd);
      int idx;
      bits = '0;
      pd   = 0;
      wait_count(1);
      for (int i = 0; i < 8; i++) begin
         idx = (int'(cnt) + N - 1) % N;
         bits[idx] = pwm_out;
         if (period_done) pd++;
         duty_bus.duty_valid = 1'b0;
         stop = 1'b0;
         if (ld_at >= 0 && int'(cnt) == ld_at) begin
            duty_bus.duty_in    = (X+1)'(ld_val);
            duty_bus.duty_valid = 1'b1;
         end
         if (ld_at >= 0 && int'(cnt) == ld_at + 1) begin
            chk("ready low while pending", 32'(duty_bus.duty_ready), 32'(0));
            duty_bus.duty_in    = (X+1)'(2);
            duty_bus.duty_valid = 1'b1;
         end
         if (int'(cnt) == stop_at) stop = 1'b1;
         step();
      end
      duty_bus.duty_valid = 1'b0;
      stop = 1'b0;
   endtask

   // Cycles and high cycles between period_done pulses, with an optional
   // 3-cycle enable stall at count sc.
   task automatic measure(input int sc, output int n, output int h);
      int t = 0;
      int stall_left = 0;
      bit stalled = 0;
      n = 0;
      h = 0;
      while (!period_done && t < 40) begin step(); t++; end
      if (t >= 40) chk("sync period_done timeout", 32'(t), 32'(0));
      for (int i = 0; i < 40; i++) begin
         step();
         n++;
         if (pwm_out) h++;
         if (period_done) break;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) enable = 1'b1;
         end else if (!stalled && int'(cnt) == sc) begin
            enable     = 1'b0;
            stalled    = 1;
            stall_left = 3;
         end
      end
   endtask

   initial begin
      logic [7:0] bits;
      int pd, n, h;

      duty_bus.duty_in    = '0;
      duty_bus.duty_valid = 1'b0;
      step();
      chk("reset pwm_out", 32'(pwm_out), 0);
      chk("reset period_done", 32'(period_done), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset duty_ready", 32'(duty_bus.duty_ready), 1);
      step();
      reset = 1'b0;

      // Duty 3 loaded in IDLE, then start.
      duty_bus.duty_in    = 4'd3;
      duty_bus.duty_valid = 1'b1;
      step();
      duty_bus.duty_valid = 1'b0;
      chk("idle load full", 32'(duty_bus.duty_ready), 0);
      wait_count(3);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("armed busy", 32'(busy), 1);
      wait_count(0);
      chk("run busy", 32'(busy), 1);
      chk("applied ready", 32'(duty_bus.duty_ready), 1);
      capture(-1, 0, -1, bits, pd);
      chk("duty3 period1", 32'(bits), 32'h07);
      chk("duty3 pd1", 32'(pd), 1);
      capture(-1, 0, -1, bits, pd);
      chk("duty3 period2", 32'(bits), 32'h07);

      // Duty 6 offered at count 4; second offer must be refused.
      capture(4, 6, -1, bits, pd);
      chk("update current period", 32'(bits), 32'h07);
      capture(-1, 0, -1, bits, pd);
      chk("update next period", 32'(bits), 32'h3F);
      chk("update ready after apply", 32'(duty_bus.duty_ready), 1);
      capture(-1, 0, -1, bits, pd);
      chk("second offer dropped", 32'(bits), 32'h3F);

      // Boundary duties.
      set_duty(0);
      capture(-1, 0, -1, bits, pd);
      chk("duty0 low", 32'(bits), 32'h00);
      chk("duty0 pd", 32'(pd), 1);
      set_duty(8);
      capture(-1, 0, -1, bits, pd);
      chk("duty8 high", 32'(bits), 32'hFF);
      set_duty(0);
      capture(-1, 0, -1, bits, pd);
      set_duty(12);
      capture(-1, 0, -1, bits, pd);
      chk("duty12 clamped", 32'(bits), 32'hFF);

      // Stop at count 2 with duty 5.
      set_duty(5);
      capture(-1, 0, 2, bits, pd);
      chk("stop period", 32'(bits), 32'h1F);
      chk("stop pd", 32'(pd), 1);
      chk("stopped pwm", 32'(pwm_out), 0);
      chk("stopped busy", 32'(busy), 0);
      capture(-1, 0, -1, bits, pd);
      chk("idle period low", 32'(bits), 32'h00);
      chk("idle no pd", 32'(pd), 0);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("start+stop busy", 32'(busy), 0);
      step();
      chk("start+stop busy later", 32'(busy), 0);

      // Enable stalls with duty 5 active.
      wait_count(3);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_count(0);
      measure(-1, n, h);
      chk("nostall len", 32'(n), 8);
      chk("nostall high", 32'(h), 5);
      measure(2, n, h);
      chk("stall lo len", 32'(n), 11);
      chk("stall lo high", 32'(h), 8);
      measure(6, n, h);
      chk("stall hi len", 32'(n), 11);
      chk("stall hi high", 32'(h), 5);

      // Reset at count 5 with a pending duty.
      set_duty(6);
      chk("pending before reset", 32'(duty_bus.duty_ready), 0);
      chk("pwm before reset", 32'(pwm_out), 1);
      reset = 1'b1;
      #1;
      chk("reset pwm", 32'(pwm_out), 0);
      chk("reset ready", 32'(duty_bus.duty_ready), 1);
      chk("reset busy mid", 32'(busy), 0);
      step();
      reset = 1'b0;
      wait_count(3);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_count(0);
      chk("rearm busy", 32'(busy), 1);
      capture(-1, 0, -1, bits, pd);
      chk("rearm duty0", 32'(bits), 32'h00);
      chk("rearm pd", 32'(pd), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
